// File: rtl/sobel_magnitude.sv
// Sobel gradient magnitude stage: |gx|+|gy| clamped to pixel width, frame-border suppression,
// and edge flag against a per-beat threshold. Two-register pipeline with valid/ready backpressure.
module sobel_magnitude #(
  parameter int WIDTH_P  = 8,
  parameter int DEPTH_P  = 16,
  parameter int HEIGHT_P = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        valid_i,
  output logic                        ready_o,
  input  logic signed [2*WIDTH_P-1:0] gx_i,
  input  logic signed [2*WIDTH_P-1:0] gy_i,
  input  logic        [WIDTH_P-1:0]   thresh_i,
  output logic                        valid_o,
  input  logic                        ready_i,
  output logic        [WIDTH_P-1:0]   mag_o,
  output logic                        edge_o,
  output logic                        last_o
);

  localparam int GW = 2 * WIDTH_P;
  localparam int CW = (DEPTH_P > 1) ? $clog2(DEPTH_P) : 1;
  localparam int RW = (HEIGHT_P > 1) ? $clog2(HEIGHT_P) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(DEPTH_P - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT_P - 1);
  localparam logic [GW:0]   PIX_MAX  = (GW+1)'({WIDTH_P{1'b1}});

  // The most negative gradient has no positive twin; pin it to the largest positive value.
  function automatic logic [GW-1:0] abs_sat(input logic signed [GW-1:0] v);
    logic [GW-1:0] r;
    if (v[GW-1] && (v[GW-2:0] == '0)) r = {1'b0, {(GW-1){1'b1}}};
    else if (v[GW-1])                 r = $unsigned(-v);
    else                              r = $unsigned(v);
    return r;
  endfunction

  function automatic logic [WIDTH_P-1:0] clamp_pix(input logic [GW:0] s);
    logic [WIDTH_P-1:0] r;
    if (s > PIX_MAX) r = '1;
    else             r = s[WIDTH_P-1:0];
    return r;
  endfunction

  logic                vld_p1, vld_p2;
  logic                s1_load, s2_load, accept;
  logic [CW-1:0]       col_q;
  logic [RW-1:0]       row_q;
  logic                at_border, at_last;

  logic [GW-1:0]       ax_p1, ay_p1;
  logic [WIDTH_P-1:0]  thresh_p1;
  logic                border_p1, last_p1;

  logic [GW:0]         sum_c;
  logic [WIDTH_P-1:0]  mag_c;
  logic                edge_c;

  logic [WIDTH_P-1:0]  mag_p2;
  logic                edge_p2, last_p2;

  assign s2_load = !vld_p2 || ready_i;
  assign s1_load = !vld_p1 || s2_load;
  assign ready_o = !vld_p1 || !vld_p2 || ready_i;
  assign accept  = valid_i && ready_o;

  assign at_border = (row_q < RW'(2)) || (col_q < CW'(2));
  assign at_last   = (row_q == ROW_LAST) && (col_q == COL_LAST);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      if (s1_load) vld_p1 <= valid_i;
      if (s2_load) vld_p2 <= vld_p1;
    end
  end

  // Raster position of the next accepted beat.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      col_q <= '0;
      row_q <= '0;
    end else if (accept) begin
      if (col_q == COL_LAST) begin
        col_q <= '0;
        row_q <= (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
      end else begin
        col_q <= col_q + CW'(1);
      end
    end
  end

  // ---- stage 1: absolute values, position flags, threshold capture ----
  always_ff @(posedge clk_i) begin
    if (accept) begin
      ax_p1     <= abs_sat(gx_i);
      ay_p1     <= abs_sat(gy_i);
      thresh_p1 <= thresh_i;
      border_p1 <= at_border;
      last_p1   <= at_last;
    end
  end

  always_comb begin
    sum_c  = {1'b0, ax_p1} + {1'b0, ay_p1};
    mag_c  = border_p1 ? '0 : clamp_pix(sum_c);
    edge_c = !border_p1 && (mag_c > thresh_p1);
  end

  // ---- stage 2: clamped magnitude and edge flag, held while downstream stalls ----
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mag_p2  <= '0;
      edge_p2 <= 1'b0;
      last_p2 <= 1'b0;
    end else if (s2_load && vld_p1) begin
      mag_p2  <= mag_c;
      edge_p2 <= edge_c;
      last_p2 <= last_p1;
    end
  end

  assign valid_o = vld_p2;
  assign mag_o   = mag_p2;
  assign edge_o  = edge_p2;
  assign last_o  = last_p2;

endmodule

// File: tb/tb_sobel_magnitude.sv
// Directed bench for sobel_magnitude: raster-position model with an expected-beat queue,
// per-cycle output checks, stall-stability checks and literal spot values.
module tb_sobel_magnitude;

  logic               clk_i = 1'b0;
  logic               rst_i;
  logic               valid_i;
  logic               ready_o;
  logic signed [15:0] gx_i, gy_i;
  logic        [7:0]  thresh_i;
  logic               valid_o;
  logic               ready_i;
  logic        [7:0]  mag_o;
  logic               edge_o;
  logic               last_o;

  sobel_magnitude #(.WIDTH_P(8), .DEPTH_P(16), .HEIGHT_P(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
    .gx_i(gx_i), .gy_i(gy_i), .thresh_i(thresh_i),
    .valid_o(valid_o), .ready_i(ready_i),
    .mag_o(mag_o), .edge_o(edge_o), .last_o(last_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { int mag; int edg; int lst; } exp_t;
  exp_t exp_q[$];

  int n_chk = 0, n_pass = 0;
  int cyc = 0, n_acc = 0, out_idx = 0;
  int first_acc = -1, first_out = -1, last_out = -1, ro_low = 0;
  int out_mag[1024];
  int out_edge[1024];
  int out_last[1024];
  bit last_acc = 0, rand_rdy = 0, prev_stall = 0;
  int p_mag, p_edge, p_last;

  task automatic chk(input string name, input int act, input int req);
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
  endtask

  // Specification-level expectation for the n-th beat of a frame stream.
  function automatic exp_t model(input int idx, input int gx, input int gy, input int th);
    exp_t e;
    int row, col, sum;
    row = (idx / 16) % 16;
    col = idx % 16;
    sum = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    e.mag = (row < 2 || col < 2) ? 0 : (sum > 255 ? 255 : sum);
    e.edg = (e.mag > th) ? 1 : 0;
    e.lst = (row == 15 && col == 15) ? 1 : 0;
    return e;
  endfunction

  // Observe the cycle at the falling edge: record accepts, compare output handshakes.
  task automatic monitor();
    exp_t e;
    int gx, gy;
    cyc++;
    if (rst_i) begin
      exp_q.delete();
      n_acc = 0; out_idx = 0; first_acc = -1; first_out = -1; last_out = -1;
      ro_low = 0; prev_stall = 0; last_acc = 0;
      return;
    end
    if (!ready_o) ro_low++;
    if (prev_stall) begin
      chk("stall_valid_held", int'(valid_o), 1);
      chk("stall_mag_held", int'(mag_o), p_mag);
      chk("stall_edge_held", int'(edge_o), p_edge);
      chk("stall_last_held", int'(last_o), p_last);
    end
    prev_stall = valid_o && !ready_i;
    p_mag = mag_o; p_edge = edge_o; p_last = last_o;

    last_acc = valid_i && ready_o;
    if (last_acc) begin
      gx = gx_i; gy = gy_i;
      exp_q.push_back(model(n_acc, gx, gy, int'(thresh_i)));
      if (first_acc < 0) first_acc = cyc;
      n_acc++;
    end
    if (valid_o && first_out < 0) first_out = cyc;
    if (valid_o && ready_i) begin
      chk("beat_expected", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("mag_o", int'(mag_o), e.mag);
        chk("edge_o", int'(edge_o), e.edg);
        chk("last_o", int'(last_o), e.lst);
      end
      if (out_idx < 1024) begin
        out_mag[out_idx] = mag_o; out_edge[out_idx] = edge_o; out_last[out_idx] = last_o;
      end
      out_idx++;
      last_out = cyc;
    end
  endtask

  task automatic tick();
    @(negedge clk_i);
    monitor();
    @(posedge clk_i);
    #1;
    if (rand_rdy) ready_i = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input int gx, input int gy, input int th);
    bit got = 0;
    valid_i = 1'b1; gx_i = 16'(gx); gy_i = 16'(gy); thresh_i = 8'(th);
    for (int t = 0; t < 500; t++) begin
      tick();
      if (last_acc) begin got = 1; break; end
    end
    if (!got) chk("accept_within_bound", 0, 1);
    valid_i = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 3000; t++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
    chk("drain_queue_empty", exp_q.size(), 0);
    repeat (3) tick();
    chk("idle_valid_low", int'(valid_o), 0);
  endtask

  task automatic do_reset();
    rst_i = 1'b1; valid_i = 1'b0;
    tick(); tick();
    chk("rst_valid_o", int'(valid_o), 0);
    chk("rst_mag_o", int'(mag_o), 0);
    chk("rst_last_o", int'(last_o), 0);
    chk("rst_edge_o", int'(edge_o), 0);
    rst_i = 1'b0;
    chk("rst_ready_o", int'(ready_o), 1);
  endtask

  initial begin
    int cnt, diff, gx, gy;
    rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b1;
    gx_i = '0; gy_i = '0; thresh_i = '0;

    // T1: reset mid-stream with beats in flight, then counters restart at row0,col0
    do_reset();
    for (int i = 0; i < 20; i++) send(50, 50, 0);
    do_reset();
    for (int i = 0; i < 35; i++) send(50, 50, 0);
    drain();
    chk("t1_beats_after_reset", out_idx, 35);
    chk("t1_row0col0_mag", out_mag[0], 0);
    chk("t1_row2col1_mag", out_mag[33], 0);
    chk("t1_row2col2_mag", out_mag[34], 100);
    chk("t1_row2col2_edge", out_edge[34], 1);

    // T2: clamp and strict threshold at row2,col2 / row2,col3
    do_reset();
    for (int i = 0; i < 34; i++) send(0, 0, 50);
    send(-300, 100, 50);
    send(-20, 30, 50);
    drain();
    chk("t2_clamp_mag", out_mag[34], 255);
    chk("t2_clamp_edge", out_edge[34], 1);
    chk("t2_eq_thresh_mag", out_mag[35], 50);
    chk("t2_eq_thresh_edge", out_edge[35], 0);

    // T3: one full frame of constant gradient
    do_reset();
    for (int i = 0; i < 256; i++) send(10, 10, 0);
    drain();
    cnt = 0;
    for (int i = 0; i < 256; i++) if (out_mag[i] != 0) cnt++;
    chk("t3_nonzero_count", cnt, 196);
    chk("t3_row1col1_mag", out_mag[17], 0);
    chk("t3_row2col2_mag", out_mag[34], 20);
    chk("t3_last_final", out_last[255], 1);

    // T4: two frames, last_o placement and repeat of border pattern
    do_reset();
    for (int i = 0; i < 512; i++) send(10, 10, 0);
    drain();
    cnt = 0; diff = 0;
    for (int i = 0; i < 512; i++) cnt += out_last[i];
    for (int i = 0; i < 256; i++) if ((out_mag[i] != 0) != (out_mag[i+256] != 0)) diff++;
    chk("t4_last_count", cnt, 2);
    chk("t4_last_beat256", out_last[255], 1);
    chk("t4_last_beat512", out_last[511], 1);
    chk("t4_frame2_pattern", diff, 0);
    cnt = 0;
    for (int i = 256; i < 512; i++) if (out_mag[i] != 0) cnt++;
    chk("t4_frame2_nonzero", cnt, 196);

    // T5: random valid gaps and random downstream stalls over three frames
    do_reset();
    rand_rdy = 1;
    for (int i = 0; i < 768; i++) begin
      while ($urandom_range(0, 1) == 1) begin
        gx_i = 16'($urandom); tick();
      end
      gx = ($urandom_range(0, 15) == 0) ? -32768 : int'($urandom_range(0, 800)) - 400;
      gy = int'($urandom_range(0, 800)) - 400;
      send(gx, gy, int'($urandom_range(0, 255)));
    end
    drain();
    rand_rdy = 0; ready_i = 1'b1;
    chk("t5_beat_count", out_idx, 768);

    // T6: back-to-back stream with downstream always ready
    do_reset();
    for (int i = 0; i < 20; i++) send(i, 3, 10);
    drain();
    chk("t6_latency", first_out - first_acc, 2);
    chk("t6_throughput_span", last_out - first_out, 19);
    chk("t6_ready_o_low_cycles", ro_low, 0);
    chk("t6_beat_count", out_idx, 20);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
